// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and the IF/ID register, stops on a halt
// opcode, and restarts only on a downstream redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus1,
  output logic        halted,
  output logic [31:0] fetch_count
);

  // Handshake: an item moves downstream on a rising edge where out_valid and
  // out_ready are both 1; out_valid never depends on out_ready, and out_* hold
  // while out_valid=1 and out_ready=0 unless a redirect flushes the register.

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [2:0] OP_HALT = 3'b110;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        fetch;
  logic        accept;
  logic        is_halt;

  always_comb begin
    accept  = out_valid && out_ready;
    fetch   = (state_q == RUN) && !redirect_valid && (!out_valid || out_ready);
    is_halt = (imem_instr[24:22] == OP_HALT);
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = RUN;
    end else if (fetch && is_halt) begin
      state_d = HALTED;
    end
  end

  // Redirect beats everything; a fetch in the same cycle as an accept refills
  // the register, so accept alone only matters when no fetch happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= 32'd0;
      out_pc      <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        pc_q      <= redirect_pc;
        out_valid <= 1'b0;
      end else if (fetch) begin
        out_instr   <= imem_instr;
        out_pc      <= pc_q;
        out_valid   <= 1'b1;
        pc_q        <= pc_q + 32'd1;
        fetch_count <= fetch_count + 32'd1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign imem_addr    = pc_q;
  assign out_pc_plus1 = out_pc + 32'd1;
  assign halted       = (state_q == HALTED);

endmodule
